dds_wave_ctrl: RTL



---
 rtl/dds_pkg.sv | 24 ++
 rtl/dds_phase_acc.sv | 69 ++++++
 rtl/dds_wave_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared state type, RAM geometry constants and table-base helper for the DDS wave controller.
// Provides a default sample width when `WIDTH is not supplied by the build.
`ifndef WIDTH
`define WIDTH 16
`endif

package dds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HWR  = 2'd2
  } state_e;

  localparam int DDS_DEPTH  = 3072;
  localparam int TABLE_AW   = 10;
  localparam int NUM_TABLES = 3;
  localparam int RAM_AW     = 12;

  function automatic logic [RAM_AW-1:0] sel_base(input logic [1:0] sel);
    return {sel, {TABLE_AW{1'b0}}};
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with loadable frequency word and carry-out (wrap) flag.
// Optional DDS_PHASE_OFFSET_EN: registered poff_i shifts the read phase only.
module dds_phase_acc #(
  parameter int PHASE_W  = 32,
  parameter int TABLE_AW = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                adv_i,
  input  logic [PHASE_W-1:0]  fword_i,
  input  logic                fword_ld_i,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0]  poff_i,
`endif
  output logic [TABLE_AW-1:0] rd_idx_o,
  output logic                wrap_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fword_act_q, fword_act_d;
  logic [PHASE_W:0]   sum;

  assign sum    = {1'b0, phase_q} + {1'b0, fword_act_q};
  assign wrap_o = adv_i & sum[PHASE_W];

  // Clearing wins over advancing so entry to IDLE always lands on phase 0.
  always_comb begin
    phase_d     = phase_q;
    fword_act_d = fword_act_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (adv_i) begin
      phase_d = sum[PHASE_W-1:0];
    end
    if (fword_ld_i) begin
      fword_act_d = fword_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      fword_act_q <= '0;
    end else begin
      phase_q     <= phase_d;
      fword_act_q <= fword_act_d;
    end
  end

`ifdef DDS_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] poff_q;
  logic [PHASE_W-1:0] rd_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poff_q <= '0;
    end else begin
      poff_q <= poff_i;
    end
  end

  assign rd_phase = phase_q + poff_q;
  assign rd_idx_o = rd_phase[PHASE_W-1 -: TABLE_AW];
`else
  assign rd_idx_o = phase_q[PHASE_W-1 -: TABLE_AW];
`endif

endmodule

// File: rtl/dds_wave_ctrl.sv
// DDS read sequencer and host-write arbiter in front of the single-port wave RAM.
// Optional DDS_PHASE_OFFSET_EN adds the poff input (read-phase offset).
module dds_wave_ctrl #(
  parameter int PHASE_W    = 32,
  parameter int TABLE_AW   = 10,
  parameter int NUM_TABLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] fword,
  input  logic               fword_ld,
  input  logic [1:0]         wave_sel,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0] poff,
`endif
  input  logic               wr_req,
  input  logic [11:0]        wr_addr,
  input  logic [`WIDTH-1:0]  wr_data,
  output logic               wr_ack,
  output logic               wr_err,
  output logic               ram_ena,
  output logic               ram_wea,
  output logic [11:0]        ram_addr,
  output logic [`WIDTH-1:0]  ram_din,
  input  logic [`WIDTH-1:0]  ram_dout,
  output logic [`WIDTH-1:0]  wave_out,
  output logic               wave_valid
);

  localparam int RAM_AW = dds_pkg::RAM_AW;
  localparam logic [RAM_AW-1:0] DEPTH_L = RAM_AW'(dds_pkg::DDS_DEPTH);

  dds_pkg::state_e     state_q, state_d;
  logic                ack_q;
  logic [1:0]          sel_act_q, sel_act_d, sel_lat;
  logic                rd_issue, rd_q;
  logic [`WIDTH-1:0]   wave_out_q, wave_out_d;
  logic                wave_valid_q;
  logic                acc_adv, acc_clr, acc_wrap;
  logic [TABLE_AW-1:0] rd_idx;
  logic [RAM_AW-1:0]   rd_addr;
  logic                wr_bad;

  assign acc_adv = (state_q == dds_pkg::RUN) || ((state_q == dds_pkg::HWR) && en);
  assign acc_clr = (state_d == dds_pkg::IDLE);

  dds_phase_acc #(
    .PHASE_W  (PHASE_W),
    .TABLE_AW (TABLE_AW)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (acc_clr),
    .adv_i      (acc_adv),
    .fword_i    (fword),
    .fword_ld_i (fword_ld),
`ifdef DDS_PHASE_OFFSET_EN
    .poff_i     (poff),
`endif
    .rd_idx_o   (rd_idx),
    .wrap_o     (acc_wrap)
  );

  assign rd_addr = dds_pkg::sel_base(sel_act_q) + {{(RAM_AW-TABLE_AW){1'b0}}, rd_idx};
  assign wr_bad  = (wr_addr >= DEPTH_L);

  // Table changes only at a phase wrap (or while idle) so a period is never split.
  assign sel_lat   = (wave_sel < 2'(NUM_TABLES)) ? wave_sel : 2'd0;
  assign sel_act_d = ((state_q == dds_pkg::IDLE) || acc_wrap) ? sel_lat : sel_act_q;

  // ack_q blocks a write right after an ack, guaranteeing a read slot in between.
  always_comb begin
    state_d  = state_q;
    ram_ena  = 1'b0;
    ram_wea  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    wr_ack   = 1'b0;
    wr_err   = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      dds_pkg::IDLE, dds_pkg::RUN: begin
        if (wr_req && !ack_q) begin
          state_d = dds_pkg::HWR;
        end else begin
          state_d = en ? dds_pkg::RUN : dds_pkg::IDLE;
        end
        if (state_q == dds_pkg::RUN) begin
          ram_ena  = 1'b1;
          ram_addr = rd_addr;
          rd_issue = 1'b1;
        end
      end
      dds_pkg::HWR: begin
        state_d  = en ? dds_pkg::RUN : dds_pkg::IDLE;
        ram_ena  = 1'b1;
        ram_wea  = !wr_bad;
        ram_addr = wr_addr;
        ram_din  = wr_data;
        wr_ack   = 1'b1;
        wr_err   = wr_bad;
      end
      default: state_d = dds_pkg::IDLE;
    endcase
  end

  assign wave_out_d = rd_q ? ram_dout : wave_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= dds_pkg::IDLE;
      ack_q        <= 1'b0;
      sel_act_q    <= 2'd0;
      rd_q         <= 1'b0;
      wave_out_q   <= '0;
      wave_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= wr_ack;
      sel_act_q    <= sel_act_d;
      rd_q         <= rd_issue;
      wave_out_q   <= wave_out_d;
      wave_valid_q <= rd_q;
    end
  end

  assign wave_out   = wave_out_q;
  assign wave_valid = wave_valid_q;

endmodule
